// File: rtl/lnrv_icb_splt.sv
// ICB 1-to-N splitter: address-decoded command fan-out with an in-order
// outstanding-id FIFO steering responses back upstream. Unmapped addresses
// go to an internal default slave that answers with an error.
module lnrv_icb_splt #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ICB_COUNT  = 4,
  parameter int P_OTS_COUNT  = 2,
  parameter logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0] P_BASE_ADDR =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0] P_ADDR_MASK = {4{32'hF000_0000}}
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  m_icb_cmd_vld,
  output logic                                  m_icb_cmd_rdy,
  input  logic                                  m_icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]               m_icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]               m_icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0]             m_icb_cmd_wstrb,
  output logic                                  m_icb_rsp_vld,
  input  logic                                  m_icb_rsp_rdy,
  output logic [P_DATA_WIDTH-1:0]               m_icb_rsp_rdata,
  output logic                                  m_icb_rsp_err,
  output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_vld,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_cmd_rdy,
  output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_write,
  output logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]   sn_icb_cmd_addr,
  output logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]   sn_icb_cmd_wdata,
  output logic [P_ICB_COUNT*P_DATA_WIDTH/8-1:0] sn_icb_cmd_wstrb,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_vld,
  output logic [P_ICB_COUNT-1:0]                sn_icb_rsp_rdy,
  input  logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]   sn_icb_rsp_rdata,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_err
);

  localparam int N  = P_ICB_COUNT;
  localparam int AW = P_ADDR_WIDTH;
  localparam int DW = P_DATA_WIDTH;
  localparam int IW = P_ICB_COUNT + 1;
  localparam int PW = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
  localparam int CW = $clog2(P_OTS_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(P_OTS_COUNT);
  localparam logic [PW-1:0] PTR_LAST = PW'(P_OTS_COUNT - 1);

  // sel / head are one-hot target ids; bit N is the default slave
  logic [IW-1:0] sel;
  logic [IW-1:0] head;
  logic [IW-1:0] ots_id [P_OTS_COUNT];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          ots_full;
  logic          ots_empty;
  logic          sel_rdy;
  logic          push;
  logic          pop;

  // Address decode; lowest matching port wins, no match selects the default slave
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && ((m_icb_cmd_addr & P_ADDR_MASK[i*AW +: AW]) ==
                     (P_BASE_ADDR[i*AW +: AW] & P_ADDR_MASK[i*AW +: AW]))) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    sel[N] = !found;
  end

  // Full is taken from the registered count only, so a same-cycle pop
  // never opens the command path
  assign ots_full  = (cnt == CNT_MAX);
  assign ots_empty = (cnt == '0);

  assign sel_rdy        = (|(sel[N-1:0] & sn_icb_cmd_rdy)) | sel[N];
  assign m_icb_cmd_rdy  = !ots_full & sel_rdy;
  assign sn_icb_cmd_vld = {N{m_icb_cmd_vld & !ots_full}} & sel[N-1:0];
  assign push           = m_icb_cmd_vld & m_icb_cmd_rdy;

  assign sn_icb_cmd_write = {N{m_icb_cmd_write}};
  assign sn_icb_cmd_addr  = {N{m_icb_cmd_addr}};
  assign sn_icb_cmd_wdata = {N{m_icb_cmd_wdata}};
  assign sn_icb_cmd_wstrb = {N{m_icb_cmd_wstrb}};

  // Only the oldest outstanding target may talk back upstream
  assign head           = ots_empty ? '0 : ots_id[rptr];
  assign sn_icb_rsp_rdy = head[N-1:0] & {N{m_icb_rsp_rdy}};
  assign m_icb_rsp_vld  = (|(head[N-1:0] & sn_icb_rsp_vld)) | head[N];
  assign m_icb_rsp_err  = (|(head[N-1:0] & sn_icb_rsp_err)) | head[N];
  assign pop            = m_icb_rsp_vld & m_icb_rsp_rdy;

  // Response data mux; default slave returns zero
  always_comb begin
    m_icb_rsp_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (head[i]) m_icb_rsp_rdata = m_icb_rsp_rdata | sn_icb_rsp_rdata[i*DW +: DW];
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO storage; entries are only read while counted, so no reset needed
  always_ff @(posedge clk) begin
    if (push) ots_id[wptr] <= sel;
  end

endmodule
